// File: rtl/ad_dac_pkg.sv
// Shared types and default sizing for the DAC write path.
// No logic; imported by the SPI transmit driver.
// No flow control of its own.
package ad_dac_pkg;

    localparam int DAC_WIDTH_DEF = 16;
    localparam int SCK_HALF_DEF  = 2;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT_HI,
        SHIFT_LO,
        GAP,
        LDAC
    } state_t;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator for the SPI serial clock.
// Tick every SCK_HALF enabled cycles; first tick SCK_HALF cycles after enable rises.
// No backpressure; counter reloads while disabled.
module spi_clk_div #(
    parameter int SCK_HALF = 2
) (
    input  logic clk,
    input  logic sresetn,
    input  logic en,
    output logic tick
);

    localparam int CW = $clog2(SCK_HALF + 1);
    localparam logic [CW-1:0] RELOAD = CW'(SCK_HALF - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == '0);

    always_ff @(posedge clk) begin
        if (!sresetn || !en || tick) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/ad5541_write.sv
// SPI transmit driver for a 16-bit AD5541-class DAC; optional LDAC strobe under AD5541_LDAC_EN.
// Latency: SCK_HALF*(2+2*DAC_WIDTH) cycles accept-to-done, plus SCK_HALF with LDAC.
// Backpressure: ready low for the whole frame; valid while busy is dropped, never queued.
module ad5541_write
    import ad_dac_pkg::*;
#(
    parameter int DAC_WIDTH = DAC_WIDTH_DEF,
    parameter int SCK_HALF  = SCK_HALF_DEF
) (
    input  logic                 clk,
    input  logic                 sresetn,
    input  logic [DAC_WIDTH-1:0] data,
    input  logic                 data_valid,
    output logic                 ready,
    output logic                 done,
    output logic                 cs_n,
    output logic                 sck,
    output logic                 sdi,
    output logic                 ldac_n
);

    localparam int BW = $clog2(DAC_WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DAC_WIDTH);

    generate
        if (SCK_HALF < 1) begin : g_bad_sck_half
            $error("ad5541_write: SCK_HALF must be >= 1");
        end
        if (DAC_WIDTH < 8 || DAC_WIDTH > 32) begin : g_bad_dac_width
            $error("ad5541_write: DAC_WIDTH must be in 8..32");
        end
    endgenerate

    state_t               state;
    logic [DAC_WIDTH-2:0] shreg;   // bits still to send; current bit lives in sdi
    logic [BW-1:0]        bitcnt;
    logic                 div_en;
    logic                 tick;

    assign div_en = (state != IDLE);

    spi_clk_div #(
        .SCK_HALF (SCK_HALF)
    ) u_clk_div (
        .clk     (clk),
        .sresetn (sresetn),
        .en      (div_en),
        .tick    (tick)
    );

    always_ff @(posedge clk) begin
        if (!sresetn) begin
            state  <= IDLE;
            shreg  <= '0;
            bitcnt <= '0;
            cs_n   <= 1'b1;
            sck    <= 1'b0;
            sdi    <= 1'b0;
            ldac_n <= 1'b1;
            ready  <= 1'b1;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (data_valid && ready) begin
                        shreg  <= data[DAC_WIDTH-2:0];
                        sdi    <= data[DAC_WIDTH-1];
                        bitcnt <= '0;
                        cs_n   <= 1'b0;
                        ready  <= 1'b0;
                        state  <= CS_SETUP;
                    end
                end
                CS_SETUP: begin
                    if (tick) begin
                        sck   <= 1'b1;
                        state <= SHIFT_HI;
                    end
                end
                SHIFT_HI: begin
                    // sdi moves on the falling sck edge so it is stable while sck is high
                    if (tick) begin
                        sck    <= 1'b0;
                        sdi    <= shreg[DAC_WIDTH-2];
                        shreg  <= {shreg[DAC_WIDTH-3:0], 1'b0};
                        bitcnt <= bitcnt + BW'(1);
                        state  <= SHIFT_LO;
                    end
                end
                SHIFT_LO: begin
                    if (tick) begin
                        if (bitcnt == LAST_BIT) begin
                            cs_n  <= 1'b1;
                            sdi   <= 1'b0;
                            state <= GAP;
                        end else begin
                            sck   <= 1'b1;
                            state <= SHIFT_HI;
                        end
                    end
                end
                GAP: begin
                    if (tick) begin
`ifdef AD5541_LDAC_EN
                        ldac_n <= 1'b0;
                        state  <= LDAC;
`else
                        ready  <= 1'b1;
                        done   <= 1'b1;
                        state  <= IDLE;
`endif
                    end
                end
`ifdef AD5541_LDAC_EN
                LDAC: begin
                    if (tick) begin
                        ldac_n <= 1'b1;
                        ready  <= 1'b1;
                        done   <= 1'b1;
                        state  <= IDLE;
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ad5541_write.sv
// Bench for ad5541_write: two instances (defaults, and SCK_HALF=1/DAC_WIDTH=12) against a
// cycle-index reference model and a DAC-side capture model.
module tb_ad5541_write;

    localparam int H_A = 2;
    localparam int W_A = 16;
    localparam int H_B = 1;
    localparam int W_B = 12;
`ifdef AD5541_LDAC_EN
    localparam bit LD = 1'b1;
`else
    localparam bit LD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        sresetn;
    logic [15:0] data_a;
    logic        dv_a;
    logic        ready_a, done_a, cs_n_a, sck_a, sdi_a, ldac_n_a;
    logic [11:0] data_b;
    logic        dv_b;
    logic        ready_b, done_b, cs_n_b, sck_b, sdi_b, ldac_n_b;

    always #5 clk = ~clk;

    ad5541_write #(.DAC_WIDTH(W_A), .SCK_HALF(H_A)) dut_a (
        .clk        (clk),
        .sresetn    (sresetn),
        .data       (data_a),
        .data_valid (dv_a),
        .ready      (ready_a),
        .done       (done_a),
        .cs_n       (cs_n_a),
        .sck        (sck_a),
        .sdi        (sdi_a),
        .ldac_n     (ldac_n_a)
    );

    ad5541_write #(.DAC_WIDTH(W_B), .SCK_HALF(H_B)) dut_b (
        .clk        (clk),
        .sresetn    (sresetn),
        .data       (data_b),
        .data_valid (dv_b),
        .ready      (ready_b),
        .done       (done_b),
        .cs_n       (cs_n_b),
        .sck        (sck_b),
        .sdi        (sdi_b),
        .ldac_n     (ldac_n_b)
    );

    int compared   = 0;
    int mismatched = 0;

    // Reference model: k = cycles since the accepting edge (0 = idle)
    int          k[2];
    logic [31:0] word[2];
    bit          done_exp[2];
    int          exp_upd[2];

    // DAC-side model: what a real AD5541 would latch
    bit          p_sck[2], p_cs[2], p_ldac[2], p_sdi[2];
    logic [31:0] acc[2];
    int          nbits[2];
    bit          pend[2];
    logic [31:0] pend_w[2];
    int          upd[2];
    logic [31:0] last_upd[2];

    function automatic int hh(int i);
        return (i == 0) ? H_A : H_B;
    endfunction

    function automatic int ww(int i);
        return (i == 0) ? W_A : W_B;
    endfunction

    function automatic int flen(int i);
        return hh(i) * (2 + 2 * ww(i)) + (LD ? hh(i) : 0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input int i, input bit dv, input logic [31:0] d);
        done_exp[i] = 1'b0;
        if (!sresetn) begin
            k[i] = 0;
        end else if (k[i] == 0) begin
            if (dv) begin
                k[i]    = 1;
                word[i] = d;
            end
        end else if (k[i] == flen(i)) begin
            k[i]        = 0;
            done_exp[i] = 1'b1;
            exp_upd[i]++;
        end else begin
            k[i]++;
        end
    endtask

    task automatic check_dut(input int i, input bit cs, input bit sk, input bit sd,
                             input bit ld, input bit rdy, input bit dn);
        int    H     = hh(i);
        int    W     = ww(i);
        int    kk    = k[i];
        int    cslen = H * (1 + 2 * W);
        int    b;
        bit    e_cs, e_sck, e_ld;
        string pre   = (i == 0) ? "A." : "B.";
        logic [31:0] mask = (W == 32) ? 32'hFFFF_FFFF : ((32'd1 << W) - 32'd1);

        e_cs  = !(kk >= 1 && kk <= cslen);
        e_sck = (kk > H) && (kk <= cslen) && ((((kk - H - 1) / H) % 2) == 0);
        e_ld  = !(LD && kk > H * (2 + 2 * W) && kk <= flen(i));
        chk({pre, "cs_n"},   32'(cs),  32'(e_cs));
        chk({pre, "sck"},    32'(sk),  32'(e_sck));
        chk({pre, "ldac_n"}, 32'(ld),  32'(e_ld));
        chk({pre, "ready"},  32'(rdy), 32'(kk == 0));
        chk({pre, "done"},   32'(dn),  32'(done_exp[i]));
        if (!e_cs) begin
            b = (kk <= H) ? 0 : ((((kk - H - 1) / H) + 1) / 2);
            if (b < W) chk({pre, "sdi_bit"}, 32'(sd), 32'(word[i][W-1-b]));
        end else begin
            chk({pre, "sdi_idle"}, 32'(sd), 32'd0);
        end

        if (sk && p_sck[i]) chk({pre, "sdi_hold"}, 32'(sd), 32'(p_sdi[i]));
        if (!cs && p_cs[i]) nbits[i] = 0;
        if (sk && !p_sck[i] && !cs) begin
            acc[i] = {acc[i][30:0], sd};
            nbits[i]++;
        end
        if (cs && !p_cs[i]) begin
            if (nbits[i] == W) begin
                if (LD) begin
                    pend[i]   = 1'b1;
                    pend_w[i] = acc[i];
                end else begin
                    upd[i]++;
                    last_upd[i] = acc[i];
                end
            end
            nbits[i] = 0;
        end
        if (!ld && p_ldac[i] && pend[i]) begin
            upd[i]++;
            last_upd[i] = pend_w[i];
            pend[i]     = 1'b0;
        end
        if (done_exp[i]) begin
            chk({pre, "dac_updates"}, 32'(upd[i]), 32'(exp_upd[i]));
            chk({pre, "dac_word"}, last_upd[i] & mask, word[i] & mask);
        end
        p_sck[i]  = sk;
        p_cs[i]   = cs;
        p_ldac[i] = ld;
        p_sdi[i]  = sd;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0, dv_a, 32'(data_a));
        model_edge(1, dv_b, 32'(data_b));
        #1;
        check_dut(0, cs_n_a, sck_a, sdi_a, ldac_n_a, ready_a, done_a);
        check_dut(1, cs_n_b, sck_b, sdi_b, ldac_n_b, ready_b, done_b);
    endtask

    task automatic steps(input int n);
        for (int s = 0; s < n; s++) step();
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            k[i] = 0; word[i] = '0; done_exp[i] = 1'b0; exp_upd[i] = 0;
            p_sck[i] = 1'b0; p_cs[i] = 1'b1; p_ldac[i] = 1'b1; p_sdi[i] = 1'b0;
            acc[i] = '0; nbits[i] = 0; pend[i] = 1'b0; pend_w[i] = '0;
            upd[i] = 0; last_upd[i] = '0;
        end
        sresetn = 1'b0;
        dv_a = 1'b0; data_a = '0;
        dv_b = 1'b0; data_b = '0;
        steps(3);
        sresetn = 1'b1;
        steps(2);

        // single alternating-pattern frame
        data_a = 16'hAAAA; dv_a = 1'b1;
        step();
        dv_a = 1'b0;
        steps(flen(0) + 3);

        // back-to-back with valid held high through the first frame
        data_a = 16'h00F0; dv_a = 1'b1;
        step();
        data_a = 16'hFFFF;
        steps(flen(0) + 1);
        dv_a = 1'b0;
        steps(flen(0) + 3);

        // a valid pulse mid-frame must be ignored
        data_a = 16'h5A3C; dv_a = 1'b1;
        step();
        dv_a = 1'b0;
        steps(20);
        data_a = 16'h1234; dv_a = 1'b1;
        step();
        dv_a = 1'b0;
        steps(flen(0));

        // reset asserted mid-shift aborts the frame with no DAC update
        data_a = 16'hC3E1; dv_a = 1'b1;
        data_b = 12'h5A5;  dv_b = 1'b1;
        step();
        dv_a = 1'b0; dv_b = 1'b0;
        steps(29);
        sresetn = 1'b0;
        step();
        sresetn = 1'b1;
        chk("A.abort_no_update", 32'(upd[0]), 32'(exp_upd[0]));
        steps(3);

        // narrow, fast instance
        data_b = 12'hABC; dv_b = 1'b1;
        step();
        dv_b = 1'b0;
        steps(flen(1) + 3);

        // random traffic on both instances, including valid while busy
        for (int c = 0; c < 1500; c++) begin
            dv_a   = ($urandom_range(0, 7) == 0);
            data_a = 16'($urandom);
            dv_b   = ($urandom_range(0, 5) == 0);
            data_b = 12'($urandom);
            step();
        end
        dv_a = 1'b0; dv_b = 1'b0;
        steps(flen(0) + 3);
        chk("A.final_updates", 32'(upd[0]), 32'(exp_upd[0]));
        chk("B.final_updates", 32'(upd[1]), 32'(exp_upd[1]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
